uart_tx_mmio: RTL and testbench

UART_TX_MMIO -- requirements
Module: uart_tx_mmio

---
 rtl/uart_tx_mmio_pkg.sv | 28 ++
 rtl/uart_tx_queue.sv | 73 +++++++
 rtl/uart_tx_mmio.sv | 149 ++++++++++++++
 tb/tb_uart_tx_mmio.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM encoding,
// register offsets and STATUS bit layout.
package uart_tx_mmio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  localparam logic [31:0] OFF_DATA   = 32'd0;
  localparam logic [31:0] OFF_STATUS = 32'd4;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_OVF   = 3;

  // Field order matches the STATUS bit indices above (ovf is bit 3).
  typedef struct packed {
    logic ovf;
    logic empty;
    logic full;
    logic busy;
  } status_t;

endpackage

// File: rtl/uart_tx_queue.sv
// Transmit byte queue. UART_TX_FIFO_EN selects a 4-entry circular FIFO;
// otherwise a single holding register is used.
module uart_tx_queue (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  logic w_push;
  logic w_pop;

  // Push while full is only accepted when a pop frees the slot in the same cycle.
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

`ifdef UART_TX_FIFO_EN
  logic [3:0][7:0] r_mem;
  logic [1:0]      r_wp;
  logic [1:0]      r_rp;
  logic [2:0]      r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem <= '0;
      r_wp  <= 2'd0;
      r_rp  <= 2'd0;
      r_cnt <= 3'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= din;
        r_wp        <= r_wp + 2'd1;
      end
      if (w_pop)
        r_rp <= r_rp + 2'd1;
      if (w_push && !w_pop)
        r_cnt <= r_cnt + 3'd1;
      else if (w_pop && !w_push)
        r_cnt <= r_cnt - 3'd1;
    end
  end

  assign dout  = r_mem[r_rp];
  assign full  = (r_cnt == 3'd4);
  assign empty = (r_cnt == 3'd0);
`else
  logic [7:0] r_hold;
  logic       r_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold <= 8'd0;
      r_vld  <= 1'b0;
    end else begin
      if (w_push)
        r_hold <= din;
      if (w_push)
        r_vld <= 1'b1;
      else if (w_pop)
        r_vld <= 1'b0;
    end
  end

  assign dout  = r_hold;
  assign full  = r_vld;
  assign empty = !r_vld;
`endif

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: DATA enqueues a byte, STATUS reports
// {overflow, empty, full, busy}; 8N1 framing at CLK_DIV clocks per bit.
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter int          CLK_DIV   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        tx
);

  localparam int            BW       = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);

  tx_state_t     r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_ovf;
  logic [31:0]   r_rdata;

  logic          w_sel_data;
  logic          w_sel_stat;
  logic          w_wr_data;
  logic          w_baud_end;
  logic          w_pop;
  logic          w_push;
  logic          w_full;
  logic          w_empty;
  logic [7:0]    w_dout;
  status_t       w_status;
  logic          w_unused;

  assign w_sel_data = (addr == BASE_ADDR + OFF_DATA);
  assign w_sel_stat = (addr == BASE_ADDR + OFF_STATUS);
  assign sel        = w_sel_data || w_sel_stat;
  assign w_wr_data  = we && w_sel_data;
  assign w_baud_end = (r_baud == BAUD_MAX);
  assign w_unused   = &{1'b0, wdata[31:8]};

  // The head is taken on the edge that enters START, from IDLE or end of STOP.
  assign w_pop  = !w_empty &&
                  ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_baud_end));
  assign w_push = w_wr_data && (!w_full || w_pop);

  uart_tx_queue u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (wdata[7:0]),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_status.ovf   = r_ovf;
  assign w_status.empty = w_empty;
  assign w_status.full  = w_full;
  assign w_status.busy  = (r_state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      if (w_wr_data && w_full && !w_pop)
        r_ovf <= 1'b1;
      else if (we && w_sel_stat && wdata[STAT_OVF])
        r_ovf <= 1'b0;
      r_rdata <= w_sel_stat ? {28'd0, w_status} : 32'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (!w_empty) begin
            r_shift <= w_dout;
            r_baud  <= '0;
            r_tx    <= 1'b0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_tx    <= r_shift[0];
            r_state <= ST_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_bit   <= 3'd0;
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        ST_STOP: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (!w_empty) begin
              r_shift <= w_dout;
              r_tx    <= 1'b0;
              r_state <= ST_START;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tx    = r_tx;
  assign rdata = r_rdata;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: register-map vector table, a line monitor that
// decodes frames against a byte scoreboard, and timed corner-case sequences.
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam int          DIV  = 4;
`ifdef UART_TX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        we    = 1'b0;
  logic [31:0] addr  = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        sel;
  logic        tx;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  uart_tx_mmio #(.BASE_ADDR(BASE), .CLK_DIV(DIV)) dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .sel   (sel),
    .tx    (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    bit         b2b;
  } exp_t;
  exp_t sb[$];

  logic prev_tx = 1'b1;
  bit   saw_rst = 1'b0;
  int   last_start = -1000;
  always @(negedge clk) prev_tx <= tx;

  task automatic mwait(int n);
    repeat (n) begin
      @(negedge clk);
      if (rst) saw_rst = 1'b1;
    end
  endtask

  initial begin : monitor
    logic [7:0] b;
    exp_t       e;
    int         t;
    forever begin
      @(negedge clk);
      if (!rst && tx == 1'b0 && prev_tx == 1'b1) begin
        saw_rst = 1'b0;
        t = cyc;
        b = 8'd0;
        mwait(DIV / 2);
        if (!saw_rst) chk("start_bit", {31'd0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          mwait(DIV);
          b[i] = tx;
        end
        mwait(DIV);
        if (!saw_rst) begin
          chk("stop_bit", {31'd0, tx}, 32'd1);
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got 0x%0h expected no frame", b);
          end else begin
            e = sb.pop_front();
            chk("frame_data", {24'd0, b}, {24'd0, e.data});
            if (e.b2b) chk("frame_gap", t - last_start, 10 * DIV);
          end
        end
        last_start = t;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [31:0] d;
    logic        s;
    logic [31:0] r;
  } vec_t;
  vec_t tbl[10];

  logic [31:0] v;
  int          t_first;
  int          t0;
  int          hi;

  task automatic wr(logic [31:0] a, logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0; wdata = 32'd0;
  endtask

  task automatic rd(logic [31:0] a, output logic [31:0] val);
    addr = a; we = 1'b0;
    @(posedge clk); #1;
    val = rdata;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", sb.size(), 0);
    repeat (2 * DIV) @(posedge clk);
    #1;
  endtask

  function automatic logic exp_bit(logic [7:0] b, int c);
    int k = c / DIV;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  initial begin
    tbl[0] = '{BASE,              1'b0, 32'h0,  1'b1, 32'h0};
    tbl[1] = '{BASE + 4,          1'b0, 32'h0,  1'b1, 32'h4};
    tbl[2] = '{BASE + 8,          1'b0, 32'h0,  1'b0, 32'h0};
    tbl[3] = '{BASE - 4,          1'b0, 32'h0,  1'b0, 32'h0};
    tbl[4] = '{BASE + 4,          1'b1, 32'h8,  1'b1, 32'h4};
    tbl[5] = '{BASE + 4,          1'b1, 32'hFF, 1'b1, 32'h4};
    tbl[6] = '{32'h0000_0000,     1'b0, 32'h0,  1'b0, 32'h0};
    tbl[7] = '{32'h7FFF_0000,     1'b0, 32'h0,  1'b0, 32'h0};
    tbl[8] = '{BASE + 8,          1'b1, 32'h99, 1'b0, 32'h0};
    tbl[9] = '{BASE + 4,          1'b0, 32'h0,  1'b1, 32'h4};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      addr = tbl[i].a; we = tbl[i].w; wdata = tbl[i].d;
      #1;
      chk($sformatf("sel[%0d]", i), {31'd0, sel}, {31'd0, tbl[i].s});
      @(posedge clk); #1;
      we = 1'b0; wdata = 32'd0;
      chk($sformatf("rdata[%0d]", i), rdata, tbl[i].r);
    end
    chk("idle_tx", {31'd0, tx}, 32'd1);

    // Single 0x55 frame, checked cycle by cycle; busy seen via STATUS one cycle late.
    sb.push_back('{8'h55, 1'b0});
    wr(BASE, 32'h55);
    addr = BASE + 4;
    for (int c = 0; c <= 41; c++) begin
      @(posedge clk); #1;
      chk($sformatf("tx55[%0d]", c), {31'd0, tx}, {31'd0, exp_bit(8'h55, c)});
      if (c >= 1 && c <= 40) chk($sformatf("busy55[%0d]", c), {31'd0, rdata[0]}, 32'd1);
      if (c == 41) chk("busy55_done", {31'd0, rdata[0]}, 32'd0);
    end
    drain();

    // Fill: first byte pops, DEPTH bytes queue, next write is dropped.
    for (int i = 0; i <= DEPTH; i++) begin
      sb.push_back('{8'(8'h10 + i), (i > 0)});
      wr(BASE, 32'(8'h10 + i));
      if (i == 0) t_first = cyc;
    end
    wr(BASE, 32'hEE);
    rd(BASE + 4, v);
    chk("status_ovf", v, 32'hB);
    wr(BASE + 4, 32'h8);
    rd(BASE + 4, v);
    chk("status_clr", v, 32'h3);

    // Write lands on the edge where STOP of the first frame pops the full queue.
    while (cyc < t_first + 40) begin
      @(posedge clk); #1;
    end
    sb.push_back('{8'hA5, 1'b1});
    wr(BASE, 32'hA5);
    rd(BASE + 4, v);
    chk("status_pushpop", v, 32'h3);
    drain();
    rd(BASE + 4, v);
    chk("status_idle", v, 32'h4);

    // Reset in the middle of data bit 3 (0xA5 bit3 = 0).
    wr(BASE, 32'hA5);
    t0 = cyc;
    while (cyc < t0 + 18) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_bit3", {31'd0, tx}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_async_tx", {31'd0, tx}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_rdata2", rdata, 32'd0);
    rd(BASE + 4, v);
    chk("status_after_rst", v, 32'h4);
    hi = 1;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) hi = 0;
    end
    chk("no_residual", hi, 1);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
